// File: rtl/csi2_pkg.sv
// Shared RAW10 packing constants and types for the CSI-2 pixel path.
package csi2_pkg;

   localparam int RAW10_PX_WIDTH    = 10;
   localparam int RAW10_PX_PER_WORD = 4;
   localparam int RAW10_IN_WIDTH    = 16;
   localparam int RAW10_WORD_WIDTH  = RAW10_PX_WIDTH * RAW10_PX_PER_WORD;
   localparam int ERR_CNT_WIDTH     = 16;

   typedef logic [1:0] px_slot_t;

endpackage

// File: rtl/axi4_stream_if.sv
// Generic AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
   parameter int DATA_W = 16,
   parameter int USER_W = 1,
   parameter int ID_W   = 1,
   parameter int DEST_W = 1
) ();

   localparam int STRB_W = (DATA_W + 7) / 8;

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [STRB_W-1:0] tstrb;
   logic [STRB_W-1:0] tkeep;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
      output tready
   );

endinterface

// File: rtl/csi2_px_deserializer.sv
// Packs one RAW10 pixel per beat into 40b words of four pixels (tuser = SOF, tlast = EOL).
// Optional framing-error counter on err_cnt_o when CSI2_PX_DESER_ERR_CNT_EN is defined.
module csi2_px_deserializer
   import csi2_pkg::*;
#(
   parameter int PX_WIDTH    = RAW10_PX_WIDTH,
   parameter int PX_PER_WORD = RAW10_PX_PER_WORD,
   parameter int IN_WIDTH    = RAW10_IN_WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_i,
   axi4_stream_if.slave  pkt_i,
   axi4_stream_if.master pkt_o
`ifdef CSI2_PX_DESER_ERR_CNT_EN
   ,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
`endif
);

   localparam int       WORD_W    = PX_WIDTH * PX_PER_WORD;
   localparam px_slot_t LAST_SLOT = px_slot_t'(PX_PER_WORD - 1);

   px_slot_t            slot_q;
   logic [WORD_W-1:0]   acc_q;
   logic                sof_q;
   logic [WORD_W-1:0]   out_data_q;
   logic                out_valid_q;
   logic                out_last_q;
   logic                out_user_q;

   logic                in_ready;
   logic                accept;
   logic [PX_WIDTH-1:0] px;
   px_slot_t            eff_slot;
   logic [WORD_W-1:0]   merged;
   logic                emit;
   logic                sof_next;

   // A tuser beat restarts the group at slot 0, discarding any partial accumulation.
   always_comb begin
      px       = pkt_i.tdata[PX_WIDTH-1:0];
      in_ready = !out_valid_q || pkt_o.tready;
      accept   = pkt_i.tvalid && in_ready;
      eff_slot = pkt_i.tuser[0] ? '0 : slot_q;
      merged   = pkt_i.tuser[0] ? '0 : acc_q;
      for (int s = 0; s < PX_PER_WORD; s++) begin
         if (eff_slot == px_slot_t'(s)) begin
            merged[s*PX_WIDTH +: PX_WIDTH] = px;
         end
      end
      emit     = accept && ((eff_slot == LAST_SLOT) || pkt_i.tlast);
      sof_next = sof_q || pkt_i.tuser[0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q      <= '0;
         acc_q       <= '0;
         sof_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
      end else begin
         if (emit) begin
            out_data_q  <= merged;
            out_valid_q <= 1'b1;
            out_last_q  <= pkt_i.tlast;
            out_user_q  <= sof_next;
         end else if (pkt_o.tready) begin
            out_valid_q <= 1'b0;
         end

         if (emit) begin
            slot_q <= '0;
            acc_q  <= '0;
            sof_q  <= 1'b0;
         end else if (accept) begin
            slot_q <= eff_slot + px_slot_t'(1);
            acc_q  <= merged;
            sof_q  <= sof_next;
         end
      end
   end

   assign pkt_i.tready = in_ready;
   assign pkt_o.tvalid = out_valid_q;
   assign pkt_o.tdata  = out_data_q;
   assign pkt_o.tlast  = out_last_q;
   assign pkt_o.tuser  = out_user_q;
   assign pkt_o.tstrb  = '1;
   assign pkt_o.tkeep  = '1;
   assign pkt_o.tid    = '0;
   assign pkt_o.tdest  = '0;

   logic unused_in;
   assign unused_in = ^{pkt_i.tdata[IN_WIDTH-1:PX_WIDTH], pkt_i.tstrb, pkt_i.tkeep,
                        pkt_i.tid, pkt_i.tdest};

`ifdef CSI2_PX_DESER_ERR_CNT_EN
   logic                     err_tuser;
   logic                     err_short;
   logic [1:0]               err_inc;
   logic [ERR_CNT_WIDTH:0]   err_sum;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

   // A tuser restart and a short line can land on the same beat, so both may count at once.
   always_comb begin
      err_tuser = accept && pkt_i.tuser[0] && (slot_q != '0);
      err_short = emit && pkt_i.tlast && (eff_slot != LAST_SLOT);
      err_inc   = {1'b0, err_tuser} + {1'b0, err_short};
      err_sum   = {1'b0, err_cnt_q} + {{(ERR_CNT_WIDTH-1){1'b0}}, err_inc};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_cnt_q <= '0;
      end else if (err_sum[ERR_CNT_WIDTH]) begin
         err_cnt_q <= '1;
      end else begin
         err_cnt_q <= err_sum[ERR_CNT_WIDTH-1:0];
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_csi2_px_deserializer.sv
// Scoreboard bench for csi2_px_deserializer; err_cnt_o checks follow CSI2_PX_DESER_ERR_CNT_EN.
module tb_csi2_px_deserializer;
   import csi2_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   axi4_stream_if #(.DATA_W(16)) in_if ();
   axi4_stream_if #(.DATA_W(40)) out_if ();

`ifdef CSI2_PX_DESER_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   csi2_px_deserializer dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pkt_i (in_if),
      .pkt_o (out_if)
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      ,
      .err_cnt_o (err_cnt)
`endif
   );

   typedef struct packed {
      logic [39:0] data;
      logic        last;
      logic        user;
   } word_t;

   word_t exp_q[$];
   word_t mon_w;
   int    checks   = 0;
   int    failures = 0;
   bit    bp_en    = 1'b0;

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] pack4(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] c, input logic [9:0] d);
      return {d, c, b, a};
   endfunction

   function automatic word_t mk(input logic [39:0] d, input logic l, input logic u);
      word_t w;
      w.data = d;
      w.last = l;
      w.user = u;
      return w;
   endfunction

   // Output handshakes are judged at negedge, where valid/ready are settled for the next edge.
   always @(negedge clk_i) begin
      if (!rst_i && out_if.tvalid && out_if.tready) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_word", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_w = exp_q.pop_front();
            check_output("word_data", 64'(out_if.tdata), 64'(mon_w.data));
            check_output("word_last", 64'(out_if.tlast), 64'(mon_w.last));
            check_output("word_user", 64'(out_if.tuser), 64'(mon_w.user));
         end
      end
   end

   always @(posedge clk_i) begin
      if (bp_en) begin
         #1 out_if.tready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic apply_stimulus(input logic [15:0] data, input logic user, input logic last);
      int n;
      bit hs;
      in_if.tdata  = data;
      in_if.tuser  = user;
      in_if.tlast  = last;
      in_if.tvalid = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs) begin
         @(negedge clk_i);
         hs = in_if.tready;
         @(posedge clk_i);
         #1;
         n++;
         if (!hs && n > 200) begin
            check_output("in_timeout", 64'(n), 64'd0);
            break;
         end
      end
      in_if.tvalid = 1'b0;
      in_if.tuser  = 1'b0;
      in_if.tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      if (exp_q.size() != 0) begin
         check_output(tag, 64'(exp_q.size()), 64'd0);
      end
      @(posedge clk_i);
      #1;
   endtask

   logic [15:0] rnd_px [16];

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_if.tvalid  = 1'b0;
      in_if.tdata   = '0;
      in_if.tuser   = '0;
      in_if.tlast   = 1'b0;
      in_if.tstrb   = '1;
      in_if.tkeep   = '1;
      in_if.tid     = '0;
      in_if.tdest   = '0;
      out_if.tready = 1'b1;
      rst_i         = 1'b1;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_output("rst_tvalid", 64'(out_if.tvalid), 64'd0);
      check_output("rst_tdata",  64'(out_if.tdata),  64'd0);
      check_output("rst_tlast",  64'(out_if.tlast),  64'd0);
      check_output("rst_tuser",  64'(out_if.tuser),  64'd0);
      check_output("rst_tkeep",  64'(out_if.tkeep),  64'h1f);
      check_output("rst_tready", 64'(in_if.tready),  64'd1);
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      check_output("rst_err", 64'(err_cnt), 64'd0);
`endif
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Two full words, no framing.
      exp_q.push_back(mk(40'h1_0030_0801, 1'b0, 1'b0));
      exp_q.push_back(mk(40'h2_0070_1805, 1'b0, 1'b0));
      for (int i = 1; i <= 8; i++) apply_stimulus(16'(i), 1'b0, 1'b0);
      wait_drain("drain_t1");

      // SOF only on the first word.
      exp_q.push_back(mk(40'h1_0030_0801, 1'b0, 1'b1));
      exp_q.push_back(mk(40'h2_0070_1805, 1'b0, 1'b0));
      for (int i = 1; i <= 8; i++) apply_stimulus(16'(i), (i == 1), 1'b0);
      wait_drain("drain_t2");

      // Six-pixel line: short second word.
      exp_q.push_back(mk(40'h1_0030_0801, 1'b0, 1'b0));
      exp_q.push_back(mk(40'h0_0000_1805, 1'b1, 1'b0));
      for (int i = 1; i <= 6; i++) apply_stimulus(16'(i), 1'b0, (i == 6));
      wait_drain("drain_t3");
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      check_output("err_short_line", 64'(err_cnt), 64'd1);
`endif

      // Output stall with a word pending.
      out_if.tready = 1'b0;
      exp_q.push_back(mk(pack4(10'd1, 10'd2, 10'd3, 10'd4), 1'b0, 1'b0));
      exp_q.push_back(mk(pack4(10'd5, 10'd6, 10'd7, 10'd8), 1'b0, 1'b0));
      for (int i = 1; i <= 4; i++) apply_stimulus(16'(i), 1'b0, 1'b0);
      fork
         begin
            for (int i = 5; i <= 8; i++) apply_stimulus(16'(i), 1'b0, 1'b0);
         end
         begin
            repeat (5) begin
               @(negedge clk_i);
               check_output("stall_in_tready", 64'(in_if.tready), 64'd0);
               check_output("stall_tdata", 64'(out_if.tdata), 64'h1_0030_0801);
            end
            @(posedge clk_i);
            #1 out_if.tready = 1'b1;
         end
      join
      wait_drain("drain_t4");

      // Upper input bits ignored.
      exp_q.push_back(mk(40'hFF_FFFF_FFFF, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) apply_stimulus(16'hFFFF, 1'b0, 1'b0);
      wait_drain("drain_t5");

      // SOF at slot 2 drops the partial group.
      apply_stimulus(16'h00AA, 1'b0, 1'b0);
      apply_stimulus(16'h00BB, 1'b0, 1'b0);
      exp_q.push_back(mk(pack4(10'h0C1, 10'h0C2, 10'h0C3, 10'h0C4), 1'b0, 1'b1));
      apply_stimulus(16'h00C1, 1'b1, 1'b0);
      apply_stimulus(16'h00C2, 1'b0, 1'b0);
      apply_stimulus(16'h00C3, 1'b0, 1'b0);
      apply_stimulus(16'h00C4, 1'b0, 1'b0);
      wait_drain("drain_t6");
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      check_output("err_tuser_slot2", 64'(err_cnt), 64'd2);
`endif

      // SOF and EOL on one beat at slot 0.
      exp_q.push_back(mk(40'h0_0000_03A5, 1'b1, 1'b1));
      apply_stimulus(16'h03A5, 1'b1, 1'b1);
      wait_drain("drain_t7");
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      check_output("err_single_px", 64'(err_cnt), 64'd3);
`endif

      // Random pixels under random output back-pressure.
      for (int i = 0; i < 16; i++) rnd_px[i] = 16'($urandom);
      for (int i = 0; i < 16; i += 4) begin
         exp_q.push_back(mk(pack4(rnd_px[i][9:0], rnd_px[i+1][9:0],
                                  rnd_px[i+2][9:0], rnd_px[i+3][9:0]), 1'b0, 1'b0));
      end
      bp_en = 1'b1;
      for (int i = 0; i < 16; i++) apply_stimulus(rnd_px[i], 1'b0, 1'b0);
      wait_drain("drain_t8");
      bp_en = 1'b0;
      @(posedge clk_i);
      #2 out_if.tready = 1'b1;

      // Reset mid-group discards accumulated pixels.
      apply_stimulus(16'h0111, 1'b0, 1'b0);
      apply_stimulus(16'h0222, 1'b0, 1'b0);
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
`ifdef CSI2_PX_DESER_ERR_CNT_EN
      check_output("err_after_reset", 64'(err_cnt), 64'd0);
`endif
      check_output("rst2_tvalid", 64'(out_if.tvalid), 64'd0);
      exp_q.push_back(mk(pack4(10'h301, 10'h302, 10'h303, 10'h304), 1'b0, 1'b0));
      for (int i = 1; i <= 4; i++) apply_stimulus(16'h0300 + 16'(i), 1'b0, 1'b0);
      wait_drain("drain_t9");

      repeat (4) @(posedge clk_i);
      check_output("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
